// File: rtl/rx_slot_pkg.sv
// rx_slot_pkg: shared state type, default configuration and counter width for the RX slot scheduler
package rx_slot_pkg;
  typedef enum logic [2:0] {IDLE, ACQUIRE, TRACK, HOLD, LOST} state_t;
  localparam int DEF_NUM_SLOTS = 5;
  localparam int DEF_SLOT_CYCLES = 200;
  localparam int DEF_FRAME_CYCLES = 1000;
  localparam int DEF_PPM_WINDOW = 8;
  localparam int DEF_MAX_MISS = 3;
  localparam int CNT_W = $clog2(DEF_FRAME_CYCLES);
endpackage

// File: rtl/rx_slot_timer.sv
// rx_slot_timer: frame counter with wrap, ppm window flag and slot decode
module rx_slot_timer
  import rx_slot_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int PPM_WINDOW = DEF_PPM_WINDOW
) (
  input  logic                 clk1m,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 locked,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic                 wrap,
  output logic                 in_window,
  output logic [2:0]           slot_idx,
  output logic                 slot_active,
  output logic                 slot_start,
  output logic                 frame_start
);
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int SW = $clog2(SLOT_CYCLES + 1);
  logic [CW-1:0] frame_cnt;
  logic [SW-1:0] slot_cnt;
  logic [7:0] mask_q;
  logic slot_end, in_slots;
  assign wrap = int'(frame_cnt) == FRAME_CYCLES - 1;
  assign in_window = int'(frame_cnt) >= FRAME_CYCLES - PPM_WINDOW;
  assign slot_end = int'(slot_cnt) == SLOT_CYCLES - 1;
  assign in_slots = int'(frame_cnt) < NUM_SLOTS * SLOT_CYCLES;
  assign slot_active = locked && in_slots && mask_q[slot_idx];
  assign slot_start = slot_active && slot_cnt == '0;
  assign frame_start = locked && frame_cnt == '0;
  // slot_idx walks with a per-slot counter and parks on the last slot through the frame tail
  always_ff @(posedge clk1m or negedge reset_n)
    if (!reset_n) begin
      frame_cnt <= '0;
      slot_cnt <= '0;
      slot_idx <= '0;
      mask_q <= '0;
    end else begin
      mask_q <= 8'(slot_mask);
      if (clr || wrap) begin
        frame_cnt <= '0;
        slot_cnt <= '0;
        slot_idx <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
        slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
        if (slot_end && slot_idx < 3'(NUM_SLOTS - 1)) slot_idx <= slot_idx + 3'd1;
      end
    end
endmodule

// File: rtl/rx_slot_scheduler.sv
// rx_slot_scheduler: ppm-locked TDMA slot scheduler with flywheel and resync.
// Optional RX_SLOT_STATS_EN adds saturating miss/early ppm counters.
module rx_slot_scheduler
  import rx_slot_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int PPM_WINDOW = DEF_PPM_WINDOW,
  parameter int MAX_MISS = DEF_MAX_MISS
) (
  input  logic                 reset_n,
  input  logic                 clk1m,
  input  logic                 enable,
  input  logic                 ppm,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic [2:0]           slot_idx,
  output logic                 slot_active,
  output logic                 slot_start,
  output logic                 frame_start,
  output logic                 locked,
  output logic                 resync_n
`ifdef RX_SLOT_STATS_EN
  ,
  output logic [15:0]          miss_total,
  output logic [15:0]          early_total
`endif
);
  localparam int MW = $clog2(MAX_MISS + 1);
  state_t state;
  logic [MW-1:0] miss;
  logic wrap, in_window, clr, miss_hit;
  assign locked = state == TRACK || state == HOLD;
  assign resync_n = state != LOST;
  assign clr = !enable || !locked || ppm;
  assign miss_hit = enable && locked && !ppm && wrap;
  rx_slot_timer #(
    .NUM_SLOTS(NUM_SLOTS), .SLOT_CYCLES(SLOT_CYCLES),
    .FRAME_CYCLES(FRAME_CYCLES), .PPM_WINDOW(PPM_WINDOW)
  ) u_timer (
    .clk1m(clk1m), .reset_n(reset_n), .clr(clr), .locked(locked),
    .slot_mask(slot_mask), .wrap(wrap), .in_window(in_window),
    .slot_idx(slot_idx), .slot_active(slot_active),
    .slot_start(slot_start), .frame_start(frame_start)
  );
  // any ppm while locked restarts the frame; LOST lasts one cycle and ignores ppm
  always_ff @(posedge clk1m or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      miss <= '0;
    end else if (!enable) begin
      state <= IDLE;
      miss <= '0;
    end else
      case (state)
        IDLE: state <= ACQUIRE;
        ACQUIRE: if (ppm) begin
          state <= TRACK;
          miss <= '0;
        end
        TRACK, HOLD:
          if (ppm) begin
            state <= TRACK;
            miss <= '0;
          end else if (wrap && int'(miss) + 1 >= MAX_MISS) begin
            state <= LOST;
            miss <= '0;
          end else if (wrap) begin
            state <= HOLD;
            miss <= miss + 1'b1;
          end
        default: state <= ACQUIRE;
      endcase
`ifdef RX_SLOT_STATS_EN
  always_ff @(posedge clk1m or negedge reset_n)
    if (!reset_n) begin
      miss_total <= '0;
      early_total <= '0;
    end else begin
      if (miss_hit && miss_total != '1) miss_total <= miss_total + 1'b1;
      if (enable && locked && ppm && !in_window && early_total != '1) early_total <= early_total + 1'b1;
    end
`else
  logic unused_stats;
  assign unused_stats = in_window ^ miss_hit;
`endif
endmodule

// File: tb/tb_rx_slot_scheduler.sv
// tb_rx_slot_scheduler: randomized scoreboard bench against a frame-position reference model
module tb_rx_slot_scheduler;
  localparam int N = 5, SL = 200, FR = 1000, W = 8, MM = 3;
  localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_HOLD = 3, M_LOST = 4;
  typedef struct packed {
    logic [2:0] idx;
    logic act;
    logic st;
    logic fs;
    logic lk;
    logic rs;
    logic [15:0] mt;
    logic [15:0] et;
  } exp_t;

  logic clk1m = 0, reset_n = 0, enable = 0, ppm = 0;
  logic [N-1:0] slot_mask = '0;
  logic [2:0] slot_idx;
  logic slot_active, slot_start, frame_start, locked, resync_n;
  logic [15:0] miss_total, early_total;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int mode = M_IDLE, pos = 0, misses = 0, miss_t = 0, early_t = 0, win_pct = 100;
  logic [N-1:0] mask_m = '0, cur_mask = 5'h1F;

  always #5 clk1m = ~clk1m;

  rx_slot_scheduler #(
    .NUM_SLOTS(N), .SLOT_CYCLES(SL), .FRAME_CYCLES(FR), .PPM_WINDOW(W), .MAX_MISS(MM)
  ) dut (
    .reset_n(reset_n), .clk1m(clk1m), .enable(enable), .ppm(ppm), .slot_mask(slot_mask),
    .slot_idx(slot_idx), .slot_active(slot_active), .slot_start(slot_start),
    .frame_start(frame_start), .locked(locked), .resync_n(resync_n)
`ifdef RX_SLOT_STATS_EN
    , .miss_total(miss_total), .early_total(early_total)
`endif
  );
`ifndef RX_SLOT_STATS_EN
  assign miss_total = 16'h0;
  assign early_total = 16'h0;
`endif

  function automatic bit model_locked();
    return mode == M_TRACK || mode == M_HOLD;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int idx;
    bit lk;
    lk = model_locked();
    idx = pos / SL;
    if (idx > N - 1) idx = N - 1;
    e.idx = 3'(idx);
    e.lk = lk;
    e.act = lk && pos < N * SL && mask_m[idx];
    e.st = e.act && pos % SL == 0;
    e.fs = lk && pos == 0;
    e.rs = mode != M_LOST;
`ifdef RX_SLOT_STATS_EN
    e.mt = 16'(miss_t);
    e.et = 16'(early_t);
`else
    e.mt = 16'h0;
    e.et = 16'h0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    pos = 0;
    misses = 0;
    mask_m = '0;
    miss_t = 0;
    early_t = 0;
  endtask

  task automatic model_next(input bit en, input bit p, input logic [N-1:0] m);
    mask_m = m;
    if (!en) begin
      mode = M_IDLE;
      pos = 0;
      misses = 0;
    end else if (mode == M_IDLE || mode == M_LOST) mode = M_ACQ;
    else if (mode == M_ACQ) begin
      if (p) begin
        mode = M_TRACK;
        pos = 0;
        misses = 0;
      end
    end else if (p) begin
      if (pos < FR - W && early_t < 16'hFFFF) early_t++;
      mode = M_TRACK;
      pos = 0;
      misses = 0;
    end else if (pos == FR - 1) begin
      misses++;
      if (miss_t < 16'hFFFF) miss_t++;
      pos = 0;
      mode = misses >= MM ? M_LOST : M_HOLD;
      if (misses >= MM) misses = 0;
    end else pos++;
  endtask

  task automatic step(input bit rst, input bit en, input bit p, input logic [N-1:0] m);
    @(posedge clk1m);
    #1;
    reset_n = !rst;
    if (rst) model_reset();
    exp_q.push_back(model_out());
    enable = en;
    ppm = p;
    slot_mask = m;
    if (!rst) model_next(en, p, m);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 3000 && !(model_locked() && pos == target); i++) step(0, 1, 0, cur_mask);
    step(0, 1, 1, cur_mask);
  endtask

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk1m);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{slot_idx, slot_active, slot_start, frame_start, locked, resync_n, miss_total, early_total};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got idx=%0d act=%b st=%b fs=%b lk=%b rs=%b mt=%0d et=%0d need idx=%0d act=%b st=%b fs=%b lk=%b rs=%b mt=%0d et=%0d",
                   $time, a.idx, a.act, a.st, a.fs, a.lk, a.rs, a.mt, a.et,
                   e.idx, e.act, e.st, e.fs, e.lk, e.rs, e.mt, e.et);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1, 0, 0, cur_mask);
    repeat (10) step(0, 1, 0, cur_mask);
    step(0, 1, 1, cur_mask);
    repeat (3) run_to(FR - 1);
    for (int i = 0; i < 3100; i++) step(0, 1, mode == M_LOST, cur_mask);
    repeat (5) step(0, 1, 0, cur_mask);
    step(0, 1, 1, cur_mask);
    run_to(500);
    cur_mask = 5'b10101;
    run_to(FR - 4);
    run_to(FR - W);
    cur_mask = 5'h1F;
    run_to(300);
    repeat (5) step(0, 0, 0, cur_mask);
    repeat (3) step(0, 1, 0, cur_mask);
    step(0, 1, 1, cur_mask);
    run_to(400);
    repeat (2) step(1, 1, 0, cur_mask);
    repeat (4) step(0, 1, 0, cur_mask);
    step(0, 1, 1, cur_mask);
    for (int c = 0; c < 40000; c++) begin
      bit lk, p, en;
      lk = model_locked();
      if (lk && pos == 0)
        case ($urandom_range(0, 2))
          0: win_pct = 0;
          1: win_pct = 25;
          default: win_pct = 100;
        endcase
      if ($urandom_range(0, 499) == 0) cur_mask = N'($urandom);
      en = $urandom_range(0, 9999) != 0;
      p = lk ? (pos >= FR - W ? $urandom_range(0, 99) < win_pct : $urandom_range(0, 2999) == 0)
             : $urandom_range(0, 29) == 0;
      step(0, en, p, cur_mask);
      if ($urandom_range(0, 19999) == 0) step(1, 1, 0, cur_mask);
    end
    repeat (4) @(negedge clk1m);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rx_slot_scheduler.md
RX_SLOT_SCHEDULER -- requirements
Module: rx_slot_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  NUM_SLOTS, 5, slots per frame (1..8).
  SLOT_CYCLES, 200, clk1m cycles per slot.
  FRAME_CYCLES, 1000, clk1m cycles per frame; must be >= NUM_SLOTS*SLOT_CYCLES.
  PPM_WINDOW, 8, acceptance window in cycles, ending at the last cycle of the frame.
  MAX_MISS, 3, consecutive missed ppm pulses before resync.
REQ-002 SHALL have ports (name, direction, width, meaning):
  reset_n  in  1  asynchronous active-low reset.
  clk1m  in  1  system clock.
  enable  in  1  scheduler enable.
  ppm  in  1  synchronous single-cycle frame-sync pulse.
  slot_mask  in  NUM_SLOTS  1 = slot used.
  slot_idx  out  3  current slot index.
  slot_active  out  1  current slot is inside the frame and unmasked.
  slot_start  out  1  1-cycle pulse on the first cycle of an active slot.
  frame_start  out  1  1-cycle pulse on frame_cnt==0.
  locked  out  1  high in TRACK or HOLD.
  resync_n  out  1  active-low 1-cycle resync request.
REQ-003 Reset SHALL be reset_n, asynchronous, active-low; clock SHALL be clk1m.

Function
REQ-004 The FSM SHALL have the states IDLE, ACQUIRE, TRACK, HOLD and LOST.
REQ-005 IDLE->ACQUIRE SHALL occur when enable=1; from any state, enable=0 SHALL force IDLE on the next cycle with all outputs at their reset values.
REQ-006 ACQUIRE: a ppm in cycle t SHALL cause TRACK and frame_cnt=0 with frame_start=1 in cycle t+1.
REQ-007 In TRACK and HOLD, frame_cnt SHALL increment each cycle and wrap FRAME_CYCLES-1 -> 0; every cycle with frame_cnt=0 SHALL assert frame_start.
REQ-008 Slot decode SHALL be slot_idx = frame_cnt / SLOT_CYCLES.
  slot_active = locked AND frame_cnt < NUM_SLOTS*SLOT_CYCLES AND slot_mask[slot_idx].
  slot_start = slot_active AND frame_cnt % SLOT_CYCLES == 0.
  Outside the slots (the frame tail), slot_idx SHALL hold NUM_SLOTS-1 and slot_active SHALL be 0.
REQ-009 A ppm is in-window when frame_cnt lies in [FRAME_CYCLES-PPM_WINDOW, FRAME_CYCLES-1]. An in-window ppm SHALL:
  set frame_cnt=0 next cycle,
  clear the miss counter,
  put the FSM in TRACK.
REQ-010 A ppm outside the window (early) SHALL restart the frame (frame_cnt=0 next cycle), clear misses and put the FSM in TRACK.
REQ-011 A wrap with no in-window ppm during that frame SHALL increment the miss counter and enter HOLD; the frame SHALL keep free-running (flywheel).
REQ-012 A ppm coinciding with frame_cnt==FRAME_CYCLES-1 SHALL count as in-window; no miss SHALL be recorded.
REQ-013 When the miss counter reaches MAX_MISS, the FSM SHALL enter LOST for exactly 1 cycle.
  In LOST: resync_n=0, locked=0, slot outputs 0.
  After LOST the FSM SHALL enter ACQUIRE.
REQ-014 A ppm arriving while in LOST SHALL be ignored.
REQ-015 slot_mask changes SHALL take effect on the next cycle; they SHALL NOT affect frame timing.

Reset
REQ-016 On reset_n=0 the block SHALL set:
  state=IDLE, frame_cnt=0, miss counter=0;
  slot_idx=0, slot_active=0, slot_start=0, frame_start=0, locked=0, resync_n=1.
REQ-017 Reset asserted mid-frame SHALL abort the frame immediately, with no resync_n pulse.

Configuration
REQ-018 Macro RX_SLOT_STATS_EN defined SHALL add:
  output miss_total [15:0], incremented per missed ppm;
  output early_total [15:0], incremented per early ppm.
  Both SHALL saturate at 16'hFFFF and be cleared by reset only.
REQ-019 Without RX_SLOT_STATS_EN, those ports and their counters SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-020 Package rx_slot_pkg SHALL hold:
  the state enum typedef;
  the default parameter constants;
  the width constant for frame_cnt, $clog2(FRAME_CYCLES).
REQ-021 Sub-module rx_slot_timer SHALL contain frame_cnt, the wrap logic and the slot decode; the top level SHALL contain the FSM and the miss logic.

Verification (defaults)
REQ-022 Reset release, enable=1, ppm at cycle 10 -> frame_start=1 and slot_start=1 with slot_idx=0 at cycle 11; slot_start again at cycles 211, 411, 611, 811.
REQ-023 Steady ppm every 1000 cycles -> locked=1 throughout, resync_n stays 1, no HOLD.
REQ-024 ppm stopped after lock:
  HOLD after the first wrap;
  frame_start keeps firing every 1000 cycles;
  resync_n=0 for 1 cycle at the 3rd missed wrap;
  locked=0, then ACQUIRE.
REQ-025 ppm at frame_cnt=500 -> frame restarts (frame_start next cycle); early_total=1 when RX_SLOT_STATS_EN is defined.
REQ-026 slot_mask=5'b10101 -> slot_start only at slots 0, 2 and 4; slot_active=0 during slots 1 and 3.
REQ-027 enable=0 in TRACK -> IDLE next cycle with all outputs at reset values; reset_n pulse mid-frame -> identical result with resync_n=1.
